// File: rtl/jtframe_multiwait_pkg.sv
// ----------------------------------------------------------------------------
// jtframe_multiwait_pkg
//
// Shared definitions for the multi-CPU clock-enable wait generator.
//   chState_e : per-channel state (RUN / STALL / CATCHUP)
//   MISS_MAXW : widest miss counter the saturating helper supports
//   satInc()  : saturating increment of a counter that is 'width' bits wide
// ----------------------------------------------------------------------------
package jtframe_multiwait_pkg;

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_STALL   = 2'd1,
        ST_CATCHUP = 2'd2
    } chState_e;

    localparam int MISS_MAXW = 16;

    // Counters narrower than MISS_MAXW are passed zero-extended. The result
    // never exceeds 2^width-1, so the caller can simply truncate it back.
    function automatic logic [MISS_MAXW-1:0] satInc(
        input logic [MISS_MAXW-1:0] value,
        input int unsigned          width
    );
        logic [MISS_MAXW-1:0] maxVal;
        maxVal = (MISS_MAXW'(1) << width) - MISS_MAXW'(1);
        if (value >= maxVal) begin
            return maxVal;
        end
        return value + MISS_MAXW'(1);
    endfunction

endpackage

// File: rtl/jtframe_multiwait_ch.sv
// ----------------------------------------------------------------------------
// jtframe_multiwait_ch
//
// One CPU channel of the wait generator. Gates the raw clock enable while
// the channel's ROM data is not ready or a shared device is busy, counts
// the enables that were swallowed, and later re-inserts them as extra
// enables in idle bus cycles.
//
// Ports
//   clk, rst_n  : clock, asynchronous active-low reset
//   start_i     : global run enable; low clears counters and blocks the CPU
//   cen_i       : raw clock enable for this CPU
//   rec_en_i    : bus idle, a recovery enable may be inserted
//   busy_i      : OR of all shared-device busy flags
//   rom_cs_i    : ROM chip select
//   rom_ok_i    : ROM data valid
//   cen_o       : registered gated / recovered clock enable
//   gate_o      : combinational run permission
//   stall_o     : registered, channel is in STALL
//   lost_o      : sticky, a miss happened with the counter saturated
// ----------------------------------------------------------------------------
module jtframe_multiwait_ch
    import jtframe_multiwait_pkg::*;
#(
    parameter int MISSW   = 4,
    parameter int RECOVER = 1,
    parameter int RECGAP  = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start_i,
    input  logic cen_i,
    input  logic rec_en_i,
    input  logic busy_i,
    input  logic rom_cs_i,
    input  logic rom_ok_i,
    output logic cen_o,
    output logic gate_o,
    output logic stall_o,
    output logic lost_o
);

    localparam int                GAPW       = (RECGAP > 1) ? $clog2(RECGAP) : 1;
    localparam logic [GAPW-1:0]   GAP_LOAD   = GAPW'((RECGAP > 1) ? (RECGAP - 1) : 0);
    localparam logic [MISSW-1:0]  MISS_MAX   = '1;
    localparam logic              RECOVER_EN = (RECOVER != 0);

    logic             last_cs_q;
    logic             locked_q;
    logic [MISSW-1:0] miss_q, miss_d;
    logic [GAPW-1:0]  gap_q,  gap_d;
    logic             lost_q, lost_d;
    logic             cen_q,  cen_d;
    chState_e         state_q, state_d;

    logic cs_rise;
    logic rom_bad;
    logic gate;
    logic missed;
    logic rec;

    // A fresh chip select always costs one cycle, even if rom_ok is already
    // high, because rom_ok may still reflect the previous address.
    assign cs_rise = rom_cs_i & ~last_cs_q;
    assign rom_bad = (rom_cs_i & ~rom_ok_i) | cs_rise;

    // locked_q stretches every stall by one cycle after the cause clears,
    // giving the CPU bus time to settle before it is clocked again.
    assign gate   = start_i & ~(rom_bad | busy_i | locked_q);
    assign missed = cen_i & ~gate;

    // Recovery only uses cycles without a real enable, so a real enable and
    // a recovered one never collide and the counter is never double-counted.
    assign rec = RECOVER_EN & start_i & (miss_q != '0) & ~cen_i & rec_en_i
               & gate & (gap_q == '0);

    // Miss counter, lost flag, gap counter and the next cen_out value.
    always_comb begin
        miss_d = miss_q;
        lost_d = lost_q;
        gap_d  = gap_q;
        cen_d  = 1'b0;
        if (!start_i) begin
            miss_d = '0;
            lost_d = 1'b0;
            gap_d  = '0;
        end else begin
            cen_d = (cen_i & gate) | rec;
            if (missed) begin
                if (miss_q == MISS_MAX) begin
                    lost_d = 1'b1;
                end else begin
                    miss_d = MISSW'(satInc(MISS_MAXW'(miss_q), MISSW));
                end
            end else if (rec) begin
                miss_d = miss_q - 1'b1;
            end
            // The gap only throttles recovery; real enables pass regardless.
            if (cen_d) begin
                gap_d = GAP_LOAD;
            end else if (gap_q != '0) begin
                gap_d = gap_q - 1'b1;
            end
        end
    end

    // Next-state logic. Decisions use the post-update miss count so that the
    // last recovery pulse drops the channel straight back to RUN.
    always_comb begin
        state_d = state_q;
        if (!start_i) begin
            state_d = ST_RUN;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (missed) begin
                        state_d = ST_STALL;
                    end
                end
                ST_STALL: begin
                    if (gate) begin
                        state_d = (miss_d != '0) ? ST_CATCHUP : ST_RUN;
                    end
                end
                ST_CATCHUP: begin
                    if (missed) begin
                        state_d = ST_STALL;
                    end else if (miss_d == '0) begin
                        state_d = ST_RUN;
                    end
                end
                default: begin
                    state_d = ST_RUN;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_cs_q <= 1'b1;
            locked_q  <= 1'b0;
            miss_q    <= '0;
            gap_q     <= '0;
            lost_q    <= 1'b0;
            cen_q     <= 1'b0;
            state_q   <= ST_RUN;
        end else begin
            last_cs_q <= rom_cs_i;
            locked_q  <= rom_bad | busy_i;
            miss_q    <= miss_d;
            gap_q     <= gap_d;
            lost_q    <= lost_d;
            cen_q     <= cen_d;
            state_q   <= state_d;
        end
    end

    assign cen_o   = cen_q;
    assign gate_o  = gate;
    assign stall_o = (state_q == ST_STALL);
    assign lost_o  = lost_q;

endmodule

// File: rtl/jtframe_multiwait.sv
// ----------------------------------------------------------------------------
// jtframe_multiwait
//
// N-channel clock-enable wait generator for cores with several CPUs that
// fetch ROM from SDRAM and share devices. Sits between the core's cen
// generator and the CPUs. Swallowed enables are re-inserted later so the
// average CPU speed is preserved.
//
// Parameters
//   CH      : number of CPU channels (1..8)
//   DEVCNT  : width of dev_busy
//   MISSW   : width of each missed-cycle counter (up to 16)
//   RECOVER : 0 disables recovery pulses
//   RECGAP  : minimum clk cycles between cen_out pulses of one channel
//
// Ports
//   clk, rst_n : clock, asynchronous active-low reset
//   start      : global run enable
//   cen_in     : raw clock enables, one per channel
//   rec_en     : per-channel bus idle, recovery allowed
//   dev_busy   : shared-device busy, any bit stalls every channel
//   rom_cs     : per-channel ROM chip select
//   rom_ok     : per-channel ROM data valid
//   cen_out    : registered gated / recovered enables
//   gate       : combinational run permission
//   stall      : registered, channel stalled
//   lost       : sticky lost-cycle overflow
// ----------------------------------------------------------------------------
module jtframe_multiwait
    import jtframe_multiwait_pkg::*;
#(
    parameter int CH      = 2,
    parameter int DEVCNT  = 2,
    parameter int MISSW   = 4,
    parameter int RECOVER = 1,
    parameter int RECGAP  = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [CH-1:0]     cen_in,
    input  logic [CH-1:0]     rec_en,
    input  logic [DEVCNT-1:0] dev_busy,
    input  logic [CH-1:0]     rom_cs,
    input  logic [CH-1:0]     rom_ok,
    output logic [CH-1:0]     cen_out,
    output logic [CH-1:0]     gate,
    output logic [CH-1:0]     stall,
    output logic [CH-1:0]     lost
);

    // Any busy shared device holds every CPU in the same cycle.
    logic busy;
    assign busy = |dev_busy;

    for (genvar i = 0; i < CH; i++) begin : g_ch
        jtframe_multiwait_ch #(
            .MISSW   (MISSW),
            .RECOVER (RECOVER),
            .RECGAP  (RECGAP)
        ) u_ch (
            .clk      (clk),
            .rst_n    (rst_n),
            .start_i  (start),
            .cen_i    (cen_in[i]),
            .rec_en_i (rec_en[i]),
            .busy_i   (busy),
            .rom_cs_i (rom_cs[i]),
            .rom_ok_i (rom_ok[i]),
            .cen_o    (cen_out[i]),
            .gate_o   (gate[i]),
            .stall_o  (stall[i]),
            .lost_o   (lost[i])
        );
    end

endmodule

// File: tb/tb_jtframe_multiwait.sv
// ----------------------------------------------------------------------------
// tb_jtframe_multiwait
//
// Drives two instances with identical inputs: dutA recovers (MISSW=2,
// RECGAP=2) and dutB never recovers (MISSW=4, RECGAP=3). A cycle-level
// model built from the behavioural rules predicts gate, cen_out, stall and
// lost for both. Directed phases are followed by a randomized phase.
// ----------------------------------------------------------------------------
module tb_jtframe_multiwait;

    localparam int CH = 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [CH-1:0] cenIn, recEn, romCs, romOk;
    logic [1:0]    devBusy;

    logic [CH-1:0] cenOutA, gateA, stallA, lostA;
    logic [CH-1:0] cenOutB, gateB, stallB, lostB;

    int passCount  = 0;
    int checkCount = 0;
    int failCount  = 0;

    // Model state, index [cfg][channel]; cfg 0 = dutA, cfg 1 = dutB
    int missM     [2][CH];
    bit lostM     [2][CH];
    bit stallM    [2][CH];
    bit cenM      [2][CH];
    int lastPulse [2][CH];
    bit prevCs    [CH];
    bit prevBad   [CH];
    bit curBad    [CH];
    logic [CH-1:0] gateExp;
    int cyc;

    int missMax [2] = '{3, 15};
    bit recOn   [2] = '{1'b1, 1'b0};
    int recGap  [2] = '{2, 3};

    jtframe_multiwait #(
        .CH(CH), .DEVCNT(2), .MISSW(2), .RECOVER(1), .RECGAP(2)
    ) dutA (
        .clk(clk), .rst_n(rst_n), .start(start), .cen_in(cenIn),
        .rec_en(recEn), .dev_busy(devBusy), .rom_cs(romCs), .rom_ok(romOk),
        .cen_out(cenOutA), .gate(gateA), .stall(stallA), .lost(lostA)
    );

    jtframe_multiwait #(
        .CH(CH), .DEVCNT(2), .MISSW(4), .RECOVER(0), .RECGAP(3)
    ) dutB (
        .clk(clk), .rst_n(rst_n), .start(start), .cen_in(cenIn),
        .rec_en(recEn), .dev_busy(devBusy), .rom_cs(romCs), .rom_ok(romOk),
        .cen_out(cenOutB), .gate(gateB), .stall(stallB), .lost(lostB)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [CH-1:0] observed,
                               input logic [CH-1:0] expected);
        checkCount = checkCount + 1;
        assert (observed === expected) passCount = passCount + 1;
        else begin
            failCount = failCount + 1;
            $error("[TB] FAIL %s observed=%b expected=%b (cycle %0d)",
                   tag, observed, expected, cyc);
        end
    endtask

    task automatic modelReset();
        for (int c = 0; c < 2; c++) begin
            for (int i = 0; i < CH; i++) begin
                missM[c][i]     = 0;
                lostM[c][i]     = 1'b0;
                stallM[c][i]    = 1'b0;
                cenM[c][i]      = 1'b0;
                lastPulse[c][i] = -1000;
            end
        end
        for (int i = 0; i < CH; i++) begin
            prevCs[i]  = 1'b1;
            prevBad[i] = 1'b0;
        end
    endtask

    // Run permission for the current inputs: a bad ROM access or busy
    // device now, or either of them in the previous cycle, blocks the CPU.
    task automatic modelGate();
        bit romBad, busy;
        busy = |devBusy;
        for (int i = 0; i < CH; i++) begin
            romBad     = (romCs[i] && !romOk[i]) || (romCs[i] && !prevCs[i]);
            curBad[i]  = romBad || busy;
            gateExp[i] = start && !romBad && !busy && !prevBad[i];
        end
    endtask

    // What happens at the clock edge: lost enables are banked and handed
    // back one at a time in idle cycles, respecting the pulse spacing.
    task automatic modelAdvance();
        bit missed, rec, out;
        for (int c = 0; c < 2; c++) begin
            for (int i = 0; i < CH; i++) begin
                if (!start) begin
                    missM[c][i]     = 0;
                    lostM[c][i]     = 1'b0;
                    stallM[c][i]    = 1'b0;
                    cenM[c][i]      = 1'b0;
                    lastPulse[c][i] = -1000;
                end else begin
                    missed = cenIn[i] && !gateExp[i];
                    rec    = recOn[c] && missM[c][i] > 0 && !cenIn[i] && recEn[i]
                             && gateExp[i] && (cyc - lastPulse[c][i] >= recGap[c]);
                    out    = (cenIn[i] && gateExp[i]) || rec;
                    if (missed) begin
                        if (missM[c][i] == missMax[c]) lostM[c][i] = 1'b1;
                        else missM[c][i]++;
                    end else if (rec) begin
                        missM[c][i]--;
                    end
                    if (out) lastPulse[c][i] = cyc;
                    if (missed) stallM[c][i] = 1'b1;
                    else if (gateExp[i]) stallM[c][i] = 1'b0;
                    cenM[c][i] = out;
                end
            end
        end
        for (int i = 0; i < CH; i++) begin
            prevCs[i]  = romCs[i];
            prevBad[i] = curBad[i];
        end
        cyc++;
    endtask

    function automatic logic [CH-1:0] packVec(input int c, input int sel);
        logic [CH-1:0] v;
        for (int i = 0; i < CH; i++) begin
            v[i] = (sel == 0) ? cenM[c][i] : (sel == 1) ? stallM[c][i] : lostM[c][i];
        end
        return v;
    endfunction

    // One clock cycle: drive at the falling edge, check the combinational
    // gate, then check the registered outputs just after the rising edge.
    task automatic applyStimulus(input logic s, input logic [CH-1:0] cen,
                                 input logic [CH-1:0] re, input logic [1:0] db,
                                 input logic [CH-1:0] cs, input logic [CH-1:0] ok);
        @(negedge clk);
        start = s; cenIn = cen; recEn = re; devBusy = db; romCs = cs; romOk = ok;
        #1;
        modelGate();
        checkOutput("gateA", gateA, gateExp);
        checkOutput("gateB", gateB, gateExp);
        modelAdvance();
        @(posedge clk);
        #1;
        checkOutput("cenOutA", cenOutA, packVec(0, 0));
        checkOutput("stallA",  stallA,  packVec(0, 1));
        checkOutput("lostA",   lostA,   packVec(0, 2));
        checkOutput("cenOutB", cenOutB, packVec(1, 0));
        checkOutput("stallB",  stallB,  packVec(1, 1));
        checkOutput("lostB",   lostB,   packVec(1, 2));
    endtask

    // Periodic enable every 4 clocks on both channels.
    task automatic runPeriodic(input int n, input logic [CH-1:0] re,
                               input logic [1:0] db, input logic [CH-1:0] ok);
        for (int k = 0; k < n; k++) begin
            applyStimulus(1'b1, (k % 4 == 0) ? 2'b11 : 2'b00, re, db, 2'b11, ok);
        end
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_cenOutA"}, cenOutA, 2'b00);
        checkOutput({tag, "_stallA"},  stallA,  2'b00);
        checkOutput({tag, "_lostA"},   lostA,   2'b00);
        checkOutput({tag, "_cenOutB"}, cenOutB, 2'b00);
        checkOutput({tag, "_stallB"},  stallB,  2'b00);
        checkOutput({tag, "_lostB"},   lostB,   2'b00);
    endtask

    initial begin
        cyc = 0;
        rst_n = 1'b0; start = 1'b0; cenIn = '0; recEn = '0; devBusy = '0;
        romCs = '1; romOk = '1;
        modelReset();
        repeat (2) @(posedge clk);
        #1;
        checkAllZero("reset");
        rst_n = 1'b1;
        $display("[TB] reset released");

        // steady ROM, no stalls: cen_out follows cen_in one clock later
        runPeriodic(24, 2'b11, 2'b00, 2'b11);
        // channel 0 ROM outage for 3 enables, then recovery
        runPeriodic(12, 2'b11, 2'b00, 2'b10);
        runPeriodic(24, 2'b11, 2'b00, 2'b11);
        // shared device busy stalls both channels
        runPeriodic(8,  2'b11, 2'b10, 2'b11);
        runPeriodic(24, 2'b11, 2'b00, 2'b11);
        // 5 misses on a 2-bit counter: saturates and flags lost
        runPeriodic(20, 2'b11, 2'b00, 2'b10);
        runPeriodic(24, 2'b11, 2'b00, 2'b11);
        checkOutput("lostStickyA", lostA & 2'b01, 2'b01);
        // recovery withheld while the bus is not idle, then resumed
        runPeriodic(12, 2'b11, 2'b00, 2'b10);
        runPeriodic(16, 2'b10, 2'b00, 2'b11);
        runPeriodic(16, 2'b11, 2'b00, 2'b11);
        // start low clears everything
        runPeriodic(8,  2'b11, 2'b00, 2'b10);
        for (int k = 0; k < 3; k++) begin
            applyStimulus(1'b0, (k == 0) ? 2'b11 : 2'b00, 2'b11, 2'b00, 2'b11, 2'b11);
        end
        checkOutput("startClearLostA", lostA, 2'b00);
        // asynchronous reset in the middle of a stall with lost set
        runPeriodic(18, 2'b11, 2'b00, 2'b10);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checkAllZero("asyncReset");
        modelReset();
        @(posedge clk);
        #1;
        checkAllZero("resetHeld");
        rst_n = 1'b1;
        runPeriodic(16, 2'b11, 2'b00, 2'b11);

        // randomized traffic
        for (int k = 0; k < 1500; k++) begin
            logic          s;
            logic [CH-1:0] cen, re, cs, ok;
            logic [1:0]    db;
            s = ($urandom_range(0, 63) != 0);
            for (int i = 0; i < CH; i++) begin
                cen[i] = ($urandom_range(0, 2) == 0);
                re[i]  = ($urandom_range(0, 3) != 0);
                ok[i]  = ($urandom_range(0, 7) != 0);
                cs[i]  = ($urandom_range(0, 5) == 0) ? ~romCs[i] : romCs[i];
            end
            db = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            applyStimulus(s, cen, re, db, cs, ok);
        end

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
